imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single simulated memory port (combinational-read DPI memory) between two requesters:
  - the instruction-fetch stage (IF, read-only);
  - the load/store unit (LS, read/write).
- Sequences every access through a configurable-latency request/response handshake, so the 5-stage pipeline can be exercised against non-ideal memory timing.
- Sits between IF/LSU and the memory access wrapper. One transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, address/data width (matches `DATA_WIDTH).
- LATENCY, 2, cycles from request acceptance to memory access; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_req_valid  input  1  IF fetch request
- if_req_ready  output  1  IF request accepted this cycle
- if_addr  input  DATA_WIDTH  fetch address
- if_resp_valid  output  1  fetch data valid
- if_resp_ready  input  1  IF consumes response
- if_rdata  output  DATA_WIDTH  fetched instruction
- ls_req_valid  input  1  LSU request
- ls_req_ready  output  1  LSU request accepted this cycle
- ls_addr  input  DATA_WIDTH  load/store address
- ls_wen  input  1  1 = store, 0 = load
- ls_wdata  input  DATA_WIDTH  store data
- ls_wmask  input  DATA_WIDTH/8  store byte mask
- ls_resp_valid  output  1  load data / store completion valid
- ls_resp_ready  input  1  LSU consumes response
- ls_rdata  output  DATA_WIDTH  load data (0 for stores)
- mem_en  output  1  one-cycle memory access strobe
- mem_wen  output  1  write strobe, only with mem_en
- mem_addr  output  DATA_WIDTH  access address
- mem_wdata  output  DATA_WIDTH  write data
- mem_wmask  output  DATA_WIDTH/8  write byte mask
- mem_rdata  input  DATA_WIDTH  combinational read data for mem_addr, valid in the mem_en cycle

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state goes to IDLE; cnt=0; last_grant=LS (so IF wins the first tie).
  - Response registers cleared.
  - All outputs 0 in the following cycle.
- Reset while WAIT/ACCESS/RESP: the in-flight transaction is dropped, no mem_en is issued, and no response is delivered.
- State machine:
  - IDLE -> WAIT
  - WAIT -> ACCESS
  - ACCESS -> RESP
  - RESP -> IDLE
- IDLE arbitration:
  - Only IF valid: if_req_ready=1.
  - Only LS valid: ls_req_ready=1.
  - Both valid: round-robin; grant the requester not equal to last_grant.
  - At most one ready is high in any cycle, and only in IDLE. Ready is 0 in all other states.
- On handshake (valid & ready) at cycle t:
  - latch owner, addr, wen (forced 0 for IF), wdata, wmask;
  - update last_grant;
  - load cnt=LATENCY-1; go to WAIT.
- WAIT: decrement cnt each cycle; when cnt==0, go to ACCESS.
- ACCESS (cycle t+LATENCY):
  - mem_en=1; mem_addr/mem_wdata/mem_wmask come from the latches; mem_wen=latched wen.
  - Capture mem_rdata into the response register (0 if store); go to RESP.
  - mem_en is high for exactly one cycle per transaction. mem_* outputs are 0 outside ACCESS.
- RESP (from cycle t+LATENCY+1):
  - Assert the owner's resp_valid; rdata is held stable.
  - The other requester's resp_valid stays 0.
  - Stay in RESP until resp_ready=1, then go to IDLE. The next request can be accepted the cycle after.
- Minimum turnaround per transaction: LATENCY+2 cycles.
- Requests arriving in non-IDLE states are held off (ready=0). Requesters must hold valid and their payload stable until ready.
- resp_ready asserted outside RESP is ignored.
- Addresses pass through unmodified. No alignment checking.

Test Plan:
- Reset, then IF req addr=0x80000000 with mem returning 0x00000413, LATENCY=2 -> if_req_ready at t; mem_en at t+2 only; if_resp_valid at t+3 with if_rdata=0x00000413; ls_resp_valid stays 0.
- IF and LS both valid in IDLE after reset -> IF granted first; after IF response completes, LS granted; third simultaneous request -> IF again (alternation).
- LS store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> single-cycle mem_en & mem_wen with those values; ls_resp_valid with ls_rdata=0.
- Backpressure: hold if_resp_ready=0 for 5 cycles in RESP -> if_rdata stable, no new grant, no extra mem_en; resp_ready=1 -> IDLE next cycle.
- rst asserted during WAIT -> next cycle all outputs 0; no mem_en ever issued for the dropped request; a fresh IF request after reset completes normally.
- LATENCY=1 build: back-to-back IF requests -> accepts spaced exactly 3 cycles with continuous resp_ready=1.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one combinational-read memory port between the instruction-fetch
// requester (read-only) and the load/store requester (read/write). Every
// access goes through a fixed-latency request/response sequence so the
// pipeline can be exercised against non-ideal memory timing. Only one
// transaction is in flight at a time.
//
// Timing for a handshake in cycle t:
//   t              IDLE, ready high, payload latched
//   t+1..t+L-1     WAIT (absent when LATENCY == 1)
//   t+L            ACCESS, single mem_en strobe, read data captured
//   t+L+1 ..       RESP until the owner asserts resp_ready
module imem_dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [DATA_WIDTH-1:0]   if_addr,
    output logic                    if_resp_valid,
    input  logic                    if_resp_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [DATA_WIDTH-1:0]   ls_addr,
    input  logic                    ls_wen,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_resp_valid,
    input  logic                    ls_resp_ready,
    output logic [DATA_WIDTH-1:0]   ls_rdata,

    output logic                    mem_en,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // Number of WAIT cycles between acceptance and the memory access.
    localparam logic [3:0] WAIT_CYCLES = 4'(LATENCY - 1);

    // Owner / last-grant encoding: 0 = instruction fetch, 1 = load/store.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;
    logic                    last_grant;
    logic                    owner;
    logic                    grant_if;
    logic                    grant_ls;
    logic                    owner_resp_ready;

    logic [DATA_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [MASK_WIDTH-1:0]   wmask_q;
    logic [DATA_WIDTH-1:0]   resp_q;

    // Round-robin arbitration in IDLE: on a tie the requester that was not
    // served last wins; a lone requester is always granted.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == ST_IDLE) begin
            if (if_req_valid && ls_req_valid) begin
                if (last_grant == OWN_LS) begin
                    grant_if = 1'b1;
                end else begin
                    grant_ls = 1'b1;
                end
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end else if (ls_req_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    // Next-state logic; cnt holds the WAIT cycles still to run, so WAIT is
    // left on its last cycle and skipped entirely when LATENCY is 1.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        owner_resp_ready = (owner == OWN_LS) ? ls_resp_ready : if_resp_ready;
        case (state)
            ST_IDLE: begin
                if (grant_if || grant_ls) begin
                    cnt_next   = WAIT_CYCLES;
                    state_next = (WAIT_CYCLES == 4'd0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (owner_resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, wait counter and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            last_grant <= OWN_LS;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (grant_if) begin
                last_grant <= OWN_IF;
            end else if (grant_ls) begin
                last_grant <= OWN_LS;
            end
        end
    end

    // Request payload latch on handshake and read-data capture in ACCESS;
    // stores return zero so the LSU sees a clean completion word.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            resp_q  <= '0;
        end else begin
            if (grant_if) begin
                owner   <= OWN_IF;
                addr_q  <= if_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end else if (grant_ls) begin
                owner   <= OWN_LS;
                addr_q  <= ls_addr;
                wen_q   <= ls_wen;
                wdata_q <= ls_wdata;
                wmask_q <= ls_wmask;
            end
            if (state == ST_ACCESS) begin
                resp_q <= wen_q ? '0 : mem_rdata;
            end
        end
    end

    // Handshake, memory strobe and response outputs, all forced to zero
    // outside the state in which they are meaningful.
    always_comb begin
        if_req_ready  = grant_if;
        ls_req_ready  = grant_ls;
        mem_en        = (state == ST_ACCESS);
        mem_wen       = mem_en && wen_q;
        mem_addr      = mem_en ? addr_q  : '0;
        mem_wdata     = mem_en ? wdata_q : '0;
        mem_wmask     = mem_en ? wmask_q : '0;
        if_resp_valid = (state == ST_RESP) && (owner == OWN_IF);
        ls_resp_valid = (state == ST_RESP) && (owner == OWN_LS);
        if_rdata      = if_resp_valid ? resp_q : '0;
        ls_rdata      = ls_resp_valid ? resp_q : '0;
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
// Directed bench: a LATENCY=2 instance covers handshake timing, round-robin,
// stores, backpressure and reset mid-transaction; a LATENCY=1 instance
// covers back-to-back acceptance spacing.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ifReqValid = 1'b0;
    logic        ifReqReady;
    logic [31:0] ifAddr = '0;
    logic        ifRespValid;
    logic        ifRespReady = 1'b1;
    logic [31:0] ifRdata;
    logic        lsReqValid = 1'b0;
    logic        lsReqReady;
    logic [31:0] lsAddr = '0;
    logic        lsWen = 1'b0;
    logic [31:0] lsWdata = '0;
    logic [3:0]  lsWmask = '0;
    logic        lsRespValid;
    logic        lsRespReady = 1'b1;
    logic [31:0] lsRdata;
    logic        memEn;
    logic        memWen;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWmask;
    logic [31:0] memRdata;

    logic        ifReqValid1 = 1'b0;
    logic        ifReqReady1;
    logic [31:0] ifAddr1 = 32'h8000_0000;
    logic        ifRespValid1;
    logic        respReady1 = 1'b1;
    logic [31:0] ifRdata1;
    logic        lsReqValid1 = 1'b0;
    logic        lsReqReady1;
    logic [31:0] lsAddr1 = '0;
    logic        lsWen1 = 1'b0;
    logic [31:0] lsWdata1 = '0;
    logic [3:0]  lsWmask1 = '0;
    logic        lsRespValid1;
    logic [31:0] lsRdata1;
    logic        memEn1;
    logic        memWen1;
    logic [31:0] memAddr1;
    logic [31:0] memWdata1;
    logic [3:0]  memWmask1;
    logic [31:0] memRdata1;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    int memEnCount = 0;
    int baseCount;
    int accepts[$];

    // Memory contents: a fixed instruction word at the reset vector, a
    // recognisable address-derived pattern everywhere else.
    function automatic logic [31:0] memModel(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0000_0413;
        return addr ^ 32'h5A5A_C3C3;
    endfunction

    assign memRdata  = memModel(memAddr);
    assign memRdata1 = memModel(memAddr1);

    imem_dmem_arbiter #(.DATA_WIDTH(32), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(ifReqValid), .if_req_ready(ifReqReady), .if_addr(ifAddr),
        .if_resp_valid(ifRespValid), .if_resp_ready(ifRespReady), .if_rdata(ifRdata),
        .ls_req_valid(lsReqValid), .ls_req_ready(lsReqReady), .ls_addr(lsAddr),
        .ls_wen(lsWen), .ls_wdata(lsWdata), .ls_wmask(lsWmask),
        .ls_resp_valid(lsRespValid), .ls_resp_ready(lsRespReady), .ls_rdata(lsRdata),
        .mem_en(memEn), .mem_wen(memWen), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_wmask(memWmask), .mem_rdata(memRdata)
    );

    imem_dmem_arbiter #(.DATA_WIDTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_valid(ifReqValid1), .if_req_ready(ifReqReady1), .if_addr(ifAddr1),
        .if_resp_valid(ifRespValid1), .if_resp_ready(respReady1), .if_rdata(ifRdata1),
        .ls_req_valid(lsReqValid1), .ls_req_ready(lsReqReady1), .ls_addr(lsAddr1),
        .ls_wen(lsWen1), .ls_wdata(lsWdata1), .ls_wmask(lsWmask1),
        .ls_resp_valid(lsRespValid1), .ls_resp_ready(respReady1), .ls_rdata(lsRdata1),
        .mem_en(memEn1), .mem_wen(memWen1), .mem_addr(memAddr1),
        .mem_wdata(memWdata1), .mem_wmask(memWmask1), .mem_rdata(memRdata1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Count memory strobes mid-cycle, away from the active edge.
    always @(negedge clk) if (memEn) memEnCount <= memEnCount + 1;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifV, input logic [31:0] ifA,
                                 input logic lsV, input logic [31:0] lsA,
                                 input logic lsW, input logic [31:0] lsD,
                                 input logic [3:0] lsM);
        ifReqValid = ifV;
        ifAddr     = ifA;
        lsReqValid = lsV;
        lsAddr     = lsA;
        lsWen      = lsW;
        lsWdata    = lsD;
        lsWmask    = lsM;
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state: every output low
        tick();
        tick();
        checkOutput("rst_if_ready",   ifReqReady,  0);
        checkOutput("rst_ls_ready",   lsReqReady,  0);
        checkOutput("rst_mem_en",     memEn,       0);
        checkOutput("rst_if_rvalid",  ifRespValid, 0);
        checkOutput("rst_ls_rvalid",  lsRespValid, 0);
        checkOutput("rst_mem_addr",   memAddr,     0);
        rst = 1'b0;
        tick();

        // Single IF fetch, LATENCY=2
        $display("[TB] single fetch");
        baseCount = memEnCount;
        applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
        checkOutput("t1_if_ready_t0", ifReqReady, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_if_ready_t1", ifReqReady, 0);
        checkOutput("t1_mem_en_t1",   memEn,      0);
        tick();
        checkOutput("t1_mem_en_t2",   memEn,      1);
        checkOutput("t1_mem_addr_t2", memAddr,    32'h8000_0000);
        checkOutput("t1_mem_wen_t2",  memWen,     0);
        tick();
        checkOutput("t1_mem_en_t3",   memEn,       0);
        checkOutput("t1_if_rvalid",   ifRespValid, 1);
        checkOutput("t1_if_rdata",    ifRdata,     32'h0000_0413);
        checkOutput("t1_ls_rvalid",   lsRespValid, 0);
        tick();
        checkOutput("t1_if_rvalid_t4", ifRespValid, 0);
        checkOutput("t1_mem_en_count", memEnCount - baseCount, 1);

        // Round-robin alternation starting from reset
        $display("[TB] round robin");
        resetDut();
        applyStimulus(1, 32'h8000_0100, 1, 32'h8000_2000, 0, 0, 0);
        checkOutput("t2_a_if_ready", ifReqReady, 1);
        checkOutput("t2_a_ls_ready", lsReqReady, 0);
        tick();
        applyStimulus(0, 0, 1, 32'h8000_2000, 0, 0, 0);
        checkOutput("t2_a_ls_held", lsReqReady, 0);
        tick();
        tick();
        checkOutput("t2_a_if_rvalid", ifRespValid, 1);
        checkOutput("t2_a_if_rdata",  ifRdata,     memModel(32'h8000_0100));
        checkOutput("t2_a_ls_rvalid", lsRespValid, 0);
        tick();
        applyStimulus(1, 32'h8000_0104, 1, 32'h8000_2000, 0, 0, 0);
        checkOutput("t2_b_ls_ready", lsReqReady, 1);
        checkOutput("t2_b_if_ready", ifReqReady, 0);
        tick();
        applyStimulus(1, 32'h8000_0104, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("t2_b_ls_rvalid", lsRespValid, 1);
        checkOutput("t2_b_ls_rdata",  lsRdata,     memModel(32'h8000_2000));
        checkOutput("t2_b_if_rvalid", ifRespValid, 0);
        tick();
        applyStimulus(1, 32'h8000_0104, 1, 32'h8000_2004, 0, 0, 0);
        checkOutput("t2_c_if_ready", ifReqReady, 1);
        checkOutput("t2_c_ls_ready", lsReqReady, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("t2_c_if_rdata", ifRdata, memModel(32'h8000_0104));
        tick();

        // LS store
        $display("[TB] store");
        applyStimulus(0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF);
        checkOutput("t3_ls_ready", lsReqReady, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t3_mem_en",    memEn,    1);
        checkOutput("t3_mem_wen",   memWen,   1);
        checkOutput("t3_mem_addr",  memAddr,  32'h8000_1000);
        checkOutput("t3_mem_wdata", memWdata, 32'hDEAD_BEEF);
        checkOutput("t3_mem_wmask", memWmask, 4'hF);
        tick();
        checkOutput("t3_mem_en_off",  memEn,       0);
        checkOutput("t3_mem_wen_off", memWen,      0);
        checkOutput("t3_ls_rvalid",   lsRespValid, 1);
        checkOutput("t3_ls_rdata",    lsRdata,     0);
        tick();

        // Backpressure on the IF response
        $display("[TB] backpressure");
        ifRespReady = 1'b0;
        applyStimulus(1, 32'h8000_0200, 0, 0, 0, 0, 0);
        checkOutput("t4_if_ready", ifReqReady, 1);
        tick();
        applyStimulus(0, 0, 1, 32'h8000_3000, 0, 0, 0);
        tick();
        tick();
        baseCount = memEnCount;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_if_rvalid_hold", ifRespValid, 1);
            checkOutput("t4_if_rdata_hold",  ifRdata,     memModel(32'h8000_0200));
            checkOutput("t4_ls_ready_hold",  lsReqReady,  0);
            checkOutput("t4_mem_en_hold",    memEn,       0);
            tick();
        end
        checkOutput("t4_no_extra_mem_en", memEnCount - baseCount, 0);
        ifRespReady = 1'b1;
        #1;
        tick();
        checkOutput("t4_if_rvalid_done", ifRespValid, 0);
        checkOutput("t4_ls_ready_idle",  lsReqReady,  1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset while waiting for the memory access
        $display("[TB] reset during wait");
        baseCount = memEnCount;
        applyStimulus(1, 32'h8000_0300, 0, 0, 0, 0, 0);
        checkOutput("t5_if_ready", ifReqReady, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        checkOutput("t5_mem_en_rst",    memEn,       0);
        checkOutput("t5_if_rvalid_rst", ifRespValid, 0);
        checkOutput("t5_mem_addr_rst",  memAddr,     0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5_no_resp", ifRespValid, 0);
        end
        checkOutput("t5_no_mem_en", memEnCount - baseCount, 0);
        applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
        checkOutput("t5_fresh_ready", ifReqReady, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t5_fresh_mem_en", memEn, 1);
        tick();
        checkOutput("t5_fresh_rvalid", ifRespValid, 1);
        checkOutput("t5_fresh_rdata",  ifRdata,     32'h0000_0413);
        tick();

        // LATENCY=1 instance: back-to-back fetches
        $display("[TB] latency 1 back-to-back");
        ifReqValid1 = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) begin
            if (ifReqReady1) accepts.push_back(cyc);
            tick();
        end
        ifReqValid1 = 1'b0;
        checkOutput("t6_accept_count", accepts.size(), 5);
        for (int i = 0; i + 1 < accepts.size(); i++) begin
            checkOutput("t6_accept_spacing", accepts[i+1] - accepts[i], 3);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
